// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word-addressed data memory with configurable wait states.
// A load or store is held by the core while stall is high. It commits on
// the edge that enters DONE. Misaligned requests are refused and set a
// sticky error flag. Memory contents survive reset.
//
// Handshake: the core holds memread/memwrite, addr and writeData steady
// while stall=1. An access is complete in the cycle where the state is DONE
// (stall=0). In that cycle readDataDMem is valid and the core may advance.
// Dropping the request before DONE aborts the access without a commit.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readDataDMem,
  output logic        stall,
  output logic        misaligned,
  output logic [15:0] accessCount
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic [31:0]   data_q;
  logic          store_q;
  logic          take;
  logic          commit;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          request;
  logic          aligned;
  logic [AW-1:0] live_idx;
  logic [AW-1:0] c_idx;
  logic [31:0]   c_data;
  logic          c_store;
  logic          commit_ok;

  // Address bits above the word index are ignored, so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:AW+2];

  assign request  = memread | memwrite;
  assign aligned  = (addr[1:0] == 2'b00);
  assign live_idx = addr[AW+1:2];

  // With zero wait states the commit happens straight from IDLE, before
  // anything has been latched, so the commit uses the live request then.
  assign c_idx     = (state_q == S_IDLE) ? live_idx  : idx_q;
  assign c_data    = (state_q == S_IDLE) ? writeData : data_q;
  assign c_store   = (state_q == S_IDLE) ? memwrite  : store_q;
  assign commit_ok = commit & reset_;

  assign stall = reset_ & request & aligned & (state_q != S_DONE);

  // State, wait counter and latched request registers.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      data_q  <= 32'd0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        idx_q   <= live_idx;
        data_q  <= writeData;
        store_q <= memwrite;
      end
    end
  end

  // Next-state logic: accept, count down or abort, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (request && aligned) begin
          take  = 1'b1;
          cnt_d = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d = S_DONE;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!request) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = S_DONE;
            commit  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Storage array; has no reset so its contents persist across reset.
  always_ff @(posedge clock) begin
    if (commit_ok && c_store) begin
      mem[c_idx] <= c_data;
    end
  end

  // Load data, access counter and sticky misalignment flag.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      readDataDMem <= 32'd0;
      accessCount  <= 16'd0;
      misaligned   <= 1'b0;
    end else begin
      if (commit) begin
        readDataDMem <= c_store ? 32'd0 : mem[c_idx];
        accessCount  <= accessCount + 16'd1;
      end
      if (state_q == S_IDLE && request && !aligned) begin
        misaligned <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with WAIT_STATES=1 and DEPTH_WORDS=256.
module tb_dmem_ctrl;

  logic        clock;
  logic        reset_;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic [31:0] readDataDMem;
  logic        stall;
  logic        misaligned;
  logic [15:0] accessCount;

  int total;
  int bad;

  dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(1)) dut (
    .clock        (clock),
    .reset_       (reset_),
    .memread      (memread),
    .memwrite     (memwrite),
    .addr         (addr),
    .writeData    (writeData),
    .readDataDMem (readDataDMem),
    .stall        (stall),
    .misaligned   (misaligned),
    .accessCount  (accessCount)
  );

  // Clock generation.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // One comparison.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start an access from IDLE and walk it to DONE (WAIT_STATES=1),
  // checking stall on each cycle. The request stays held in DONE.
  task automatic access_to_done(input logic r, input logic w,
                                input logic [31:0] a, input logic [31:0] d,
                                input string tag);
    memread = r; memwrite = w; addr = a; writeData = d;
    #1;
    chk({tag, "_stall_idle"}, 32'(stall), 32'd1);
    tick();
    chk({tag, "_stall_wait"}, 32'(stall), 32'd1);
    tick();
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
  endtask

  task automatic release_req();
    memread = 1'b0; memwrite = 1'b0;
    tick();
  endtask

  initial begin
    total = 0; bad = 0;
    reset_ = 1'b0; memread = 1'b0; memwrite = 1'b0;
    addr = 32'd0; writeData = 32'd0;
    repeat (3) tick();
    reset_ = 1'b1;
    tick();

    // Reset values and idle behaviour.
    chk("rst_rdata", readDataDMem, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mis",   32'(misaligned), 32'd0);
    chk("rst_cnt",   32'(accessCount), 32'd0);

    // Store 5 to addr 4, load it back.
    access_to_done(1'b0, 1'b1, 32'd4, 32'd5, "st4");
    chk("st4_cnt", 32'(accessCount), 32'd1);
    release_req();
    access_to_done(1'b1, 1'b0, 32'd4, 32'd0, "ld4");
    chk("ld4_rdata", readDataDMem, 32'd5);
    chk("ld4_cnt", 32'(accessCount), 32'd2);
    release_req();

    // Address wrap: 0x404 aliases word 1.
    access_to_done(1'b0, 1'b1, 32'd4, 32'hC, "st4c");
    release_req();
    access_to_done(1'b1, 1'b0, 32'h404, 32'd0, "ld404");
    chk("ld404_rdata", readDataDMem, 32'hC);
    chk("ld404_cnt", 32'(accessCount), 32'd4);
    release_req();

    // Misaligned load is refused and sets the sticky flag.
    memread = 1'b1; addr = 32'd6;
    #1;
    chk("mis_stall0", 32'(stall), 32'd0);
    tick();
    chk("mis_flag", 32'(misaligned), 32'd1);
    chk("mis_stall1", 32'(stall), 32'd0);
    tick();
    chk("mis_rdata", readDataDMem, 32'hC);
    chk("mis_cnt", 32'(accessCount), 32'd4);
    release_req();
    chk("mis_sticky", 32'(misaligned), 32'd1);

    // Aborted store to addr 8 leaves the old value.
    access_to_done(1'b0, 1'b1, 32'd8, 32'h11, "st8");
    release_req();
    memwrite = 1'b1; addr = 32'd8; writeData = 32'hAA;
    tick();
    memwrite = 1'b0;
    tick();
    chk("abort_cnt", 32'(accessCount), 32'd5);
    tick();
    access_to_done(1'b1, 1'b0, 32'd8, 32'd0, "ld8");
    chk("ld8_rdata", readDataDMem, 32'h11);
    chk("ld8_cnt", 32'(accessCount), 32'd6);
    release_req();

    // Reset during WAIT aborts a store to addr 12; memory survives.
    access_to_done(1'b0, 1'b1, 32'd12, 32'h33, "st12");
    release_req();
    memwrite = 1'b1; addr = 32'd12; writeData = 32'h77;
    tick();
    reset_ = 1'b0;
    #1;
    chk("rstw_stall", 32'(stall), 32'd0);
    tick();
    chk("rstw_cnt", 32'(accessCount), 32'd0);
    chk("rstw_rdata", readDataDMem, 32'd0);
    chk("rstw_mis", 32'(misaligned), 32'd0);
    chk("rstw_stall2", 32'(stall), 32'd0);
    reset_ = 1'b1; memwrite = 1'b0;
    tick();
    access_to_done(1'b1, 1'b0, 32'd12, 32'd0, "ld12");
    chk("ld12_rdata", readDataDMem, 32'h33);
    chk("ld12_cnt", 32'(accessCount), 32'd1);
    release_req();

    // Both read and write: behaves as a store, load data becomes 0.
    access_to_done(1'b1, 1'b1, 32'd16, 32'h99, "both16");
    chk("both16_rdata", readDataDMem, 32'd0);
    chk("both16_cnt", 32'(accessCount), 32'd2);
    release_req();
    access_to_done(1'b1, 1'b0, 32'd16, 32'd0, "ld16");
    chk("ld16_rdata", readDataDMem, 32'h99);
    chk("ld16_cnt", 32'(accessCount), 32'd3);
    release_req();
    chk("idle_stall", 32'(stall), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory responder for the single-cycle datapath. It sits on the load/store side: it accepts the datapath's `memread`/`memwrite` request with `aluout` as address and `readData2` as store data, holds the word-addressed storage, and returns `readDataDMem`. The access takes a configurable number of wait states, and the block asserts `stall` so the core freezes its PC and register-file write until the access completes.

## Interface
- `DEPTH_WORDS`, 256: storage size in 32-bit words; power of two.
- `WAIT_STATES`, 1: extra cycles spent in WAIT per access; 0..15.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset_` input 1: reset is synchronous and active-low.
- `memread` input 1: load request, level-held by the core while stalled.
- `memwrite` input 1: store request, level-held by the core while stalled.
- `addr` input 32: byte address (`aluout`).
- `writeData` input 32: store data (`readData2`).
- `readDataDMem` output 32: load data; registered.
- `stall` output 1: combinational; core must hold the PC while it is 1.
- `misaligned` output 1: sticky error flag; registered.
- `accessCount` output 16: number of completed accesses; registered, wraps.

## Operation
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Upper bits are ignored, so addresses wrap modulo `DEPTH_WORDS*4`.
- A request is `memread | memwrite`. If both are 1, the access is a store; `readDataDMem` is loaded with 0 at completion.
- Misaligned request (`addr[1:0] != 0`) in IDLE:
  - no access, no state change;
  - `misaligned` is set and held until reset;
  - `stall = 0`.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On an aligned request, latch the word index and `writeData`, load the wait counter with `WAIT_STATES`.
  - Go to WAIT, or directly to DONE if `WAIT_STATES == 0`.
- WAIT:
  - Decrement the counter; go to DONE on the edge where it reaches 0.
  - If the request drops, abort to IDLE: no commit, counter unchanged.
- On the edge entering DONE:
  - A store writes the latched data to memory.
  - A load registers `mem[index]` into `readDataDMem`.
  - `accessCount` increments.
- DONE: unconditionally return to IDLE on the next edge.
- `stall = reset_ & request & aligned & (state != DONE)`.
- `readDataDMem` holds its last value until the next completed load or store.
- Memory contents are not cleared by reset.

## Timing
- Reset values: state IDLE, `readDataDMem = 0`, `misaligned = 0`, `accessCount = 0`, counter 0.
- Reset has priority over everything: an in-flight access is aborted and not committed.
- `stall` is forced to 0 while `reset_ = 0`.
- A request held from cycle T:
  - `stall = 1` in cycles T .. T+WAIT_STATES;
  - DONE is cycle T+WAIT_STATES+1, with `stall = 0` and `readDataDMem` valid;
  - the core writes the register file and advances the PC at the end of DONE.
  - Total occupancy is WAIT_STATES+2 cycles.
- Back-to-back accesses: DONE→IDLE→new request. There is always at least one IDLE cycle between accesses, and `stall` is 0 in DONE even if the next instruction also requests.
- Non-memory instructions never stall.
- A store followed by a load to the same address returns the stored value; the write is committed before the next IDLE.
- `accessCount` wraps 0xFFFF→0x0000.

## Test plan
- Reset, then idle with no request:
  - `readDataDMem = 0`, `stall = 0`, `misaligned = 0`, `accessCount = 0`.
- WAIT_STATES=1, store `addr = 4`, `writeData = 5`, then load `addr = 4`:
  - `stall` is high for 2 cycles on each access;
  - on the load's DONE cycle, `readDataDMem = 5`;
  - `accessCount = 2`.
- Load `addr = 0x404` with DEPTH_WORDS=256 after storing 0xC at `addr = 4`:
  - `readDataDMem = 0xC` (address wrap).
- Load `addr = 6`:
  - `misaligned = 1` stays set;
  - `stall = 0`, `readDataDMem` and `accessCount` are unchanged.
- Store 0xAA to `addr = 8`, drop `memwrite` during WAIT, then load `addr = 8`:
  - the old value is returned, showing no commit.
- Store 0x77 to `addr = 12`, assert `reset_ = 0` during WAIT, then load `addr = 12`:
  - the old value is returned;
  - `accessCount` restarts at 0;
  - `stall = 0` during reset.
